time12_counter: RTL

TIME12_COUNTER -- requirements
Module: time12_counter

---
 rtl/time12_counter_if.sv | 26 ++
 rtl/time12_counter.sv | 98 +++++++++
 2 files changed

// File: rtl/time12_counter_if.sv
// Time-set bundle between the time-set stage and the 12-hour clock.
// The master drives a set time, the slave reports the running time.
interface time12_counter_if;
  logic       run;
  logic       load;
  logic [4:0] hours_i;
  logic [5:0] mins_i;
  logic [5:0] secs_i;
  logic       A_P_i;
  logic [4:0] hours_o;
  logic [5:0] mins_o;
  logic [5:0] secs_o;
  logic       A_P_o;
  logic       sec_tick;
  logic       load_err;

  modport master (
    output run, load, hours_i, mins_i, secs_i, A_P_i,
    input  hours_o, mins_o, secs_o, A_P_o, sec_tick, load_err
  );

  modport slave (
    input  run, load, hours_i, mins_i, secs_i, A_P_i,
    output hours_o, mins_o, secs_o, A_P_o, sec_tick, load_err
  );
endinterface

// File: rtl/time12_counter.sv
// 12-hour hh:mm:ss AM/PM timekeeper with a per-second prescaler,
// validated time load and one-cycle tick / load-error pulses.
module time12_counter #(
  parameter int TICKS_PER_SEC = 100000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       load,
  input  logic [4:0] hours_i,
  input  logic [5:0] mins_i,
  input  logic [5:0] secs_i,
  input  logic       A_P_i,
  output logic [4:0] hours_o,
  output logic [5:0] mins_o,
  output logic [5:0] secs_o,
  output logic       A_P_o,
  output logic       sec_tick,
  output logic       load_err
);

  localparam int PW =
    (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] TERM =
    PW'(TICKS_PER_SEC - 1);

  logic [PW-1:0] pre;
  logic          valid;
  logic          term;
  logic [4:0]    nh;
  logic [5:0]    nm;
  logic [5:0]    ns;
  logic          nap;

  assign valid = (hours_i >= 5'd1)
              && (hours_i <= 5'd12)
              && (mins_i <= 6'd59)
              && (secs_i <= 6'd59);

  assign term = (pre == TERM);

  // Time one second ahead of the current registered time.
  always_comb begin
    nh  = hours_o;
    nm  = mins_o;
    ns  = secs_o + 6'd1;
    nap = A_P_o;
    if (secs_o == 6'd59) begin
      ns = 6'd0;
      nm = mins_o + 6'd1;
      if (mins_o == 6'd59) begin
        nm = 6'd0;
        unique case (1'b1)
          (hours_o == 5'd12): nh = 5'd1;
          (hours_o == 5'd11): begin
            nh  = 5'd12;
            nap = ~A_P_o;
          end
          default: nh = hours_o + 5'd1;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hours_o  <= 5'd12;
      mins_o   <= 6'd0;
      secs_o   <= 6'd0;
      A_P_o    <= 1'b0;
      pre      <= '0;
      sec_tick <= 1'b0;
      load_err <= 1'b0;
    end else begin
      sec_tick <= 1'b0;
      load_err <= load && !valid;
      if (load && valid) begin
        hours_o <= hours_i;
        mins_o  <= mins_i;
        secs_o  <= secs_i;
        A_P_o   <= A_P_i;
        pre     <= '0;
      end else if (run) begin
        if (term) begin
          pre      <= '0;
          hours_o  <= nh;
          mins_o   <= nm;
          secs_o   <= ns;
          A_P_o    <= nap;
          sec_tick <= 1'b1;
        end else begin
          pre <= pre + 1'b1;
        end
      end
    end
  end

endmodule
